// File: rtl/indicators_pkg.sv
// Shared constants and the 7-segment hex font for the board indicator block.
package indicators_pkg;

  // Width of one displayed hex digit and of one 7-segment field.
  localparam int NIBBLE_W = 4;
  localparam int SEG_W    = 7;

  // Active-high "all segments dark" pattern; the top inverts it for INV boards.
  localparam logic [SEG_W-1:0] SEG_OFF_HI = 7'h00;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  // Lower-case b and d keep B/8 and D/0 distinguishable.
  function automatic logic [SEG_W-1:0] seg7_hex(input logic [NIBBLE_W-1:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Apply board polarity to an active-high segment pattern.
  function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] seg_hi,
                                                    input bit inv);
    return inv ? ~seg_hi : seg_hi;
  endfunction

endpackage

// File: rtl/act_stretch.sv
// One activity channel: turns a strobe (pulse or level) into a stretch of
// `hold` cycles. A new strobe reloads the counter rather than adding to it.
module act_stretch
  import indicators_pkg::*;
#(
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              act_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic              active_o
);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;
  logic [HOLD_W-1:0] load_val;

  // Next count: reload on strobe (hold of 0 behaves as 1), else count down to 0 and park.
  always_comb begin
    load_val = (hold_i == '0) ? HOLD_W'(1) : hold_i;
    cnt_d    = cnt_q;
    if (act_i) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - HOLD_W'(1);
    end
  end

  // Stretch counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Channel is lit for exactly as many cycles as the count was loaded with.
  assign active_o = (cnt_q != '0);

endmodule

// File: rtl/activity_indicators.sv
// Board indicators: stretched/blinking activity LEDs and a latched hex value
// on 7-segment digits with optional leading-zero blanking.
module activity_indicators
  import indicators_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int HOLD_W   = 16,
  parameter int DIGITS   = 4,
  parameter int BLINK_SH = 20,
  parameter bit INV      = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             act,
  input  logic [HOLD_W-1:0]          hold,
  input  logic [NCH-1:0]             blink_en,
  input  logic [NIBBLE_W*DIGITS-1:0] value,
  input  logic                       value_ld,
  input  logic                       blank_lz,
  output logic [NCH-1:0]             led,
  output logic [SEG_W*DIGITS-1:0]    hex
);

  // Dark pattern for a whole display in board polarity (used at reset).
  localparam logic [SEG_W-1:0]        SEG_OFF     = seg_polarity(SEG_OFF_HI, INV);
  localparam logic [SEG_W*DIGITS-1:0] HEX_ALL_OFF = {DIGITS{SEG_OFF}};

  genvar gi;

  // ---------------------------------------------------------------------------
  // Activity channels
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] active;

  generate
    for (gi = 0; gi < NCH; gi++) begin : gen_ch
      act_stretch #(
        .HOLD_W (HOLD_W)
      ) u_stretch (
        .clk      (clk),
        .rst      (rst),
        .act_i    (act[gi]),
        .hold_i   (hold),
        .active_o (active[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Blink phase: free-running prescaler, phase flips each time it wraps
  // ---------------------------------------------------------------------------
  logic [BLINK_SH-1:0] pre_q;
  logic [BLINK_SH-1:0] pre_d;
  logic                phase_q;
  logic                phase_d;

  // Prescaler increment and phase toggle on the all-ones count.
  always_comb begin
    pre_d   = pre_q + BLINK_SH'(1);
    phase_d = (&pre_q) ? ~phase_q : phase_q;
  end

  // Prescaler and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // LED outputs: blink-enabled channels are gated by the phase while stretched
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] led_q;
  logic [NCH-1:0] led_d;

  assign led_d = active & (~blink_en | {NCH{phase_q}});

  // Registered LED drive so the pins come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

  // ---------------------------------------------------------------------------
  // Display value latch
  // ---------------------------------------------------------------------------
  logic [NIBBLE_W*DIGITS-1:0] val_q;
  logic [NIBBLE_W*DIGITS-1:0] val_d;

  assign val_d = value_ld ? value : val_q;

  // Latched display value; only changes on an explicit load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit decode with leading-zero blanking
  // ---------------------------------------------------------------------------
  logic [SEG_W*DIGITS-1:0] hex_d;
  logic [SEG_W*DIGITS-1:0] hex_q;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : gen_digit
      logic             blank_w;
      logic [SEG_W-1:0] seg_hi_w;

      if (gi == 0) begin : gen_lsd
        // The least significant digit always shows, so a zero value reads "0".
        assign blank_w = 1'b0;
      end else begin : gen_upper
        // Blank when this digit and every digit above it are zero.
        assign blank_w = blank_lz & ~(|val_q[NIBBLE_W*DIGITS-1 : NIBBLE_W*gi]);
      end

      assign seg_hi_w = blank_w ? SEG_OFF_HI : seg7_hex(val_q[NIBBLE_W*gi +: NIBBLE_W]);
      assign hex_d[SEG_W*gi +: SEG_W] = seg_polarity(seg_hi_w, INV);
    end
  endgenerate

  // Registered segment drive; blank_lz changes show on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q <= HEX_ALL_OFF;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex = hex_q;

endmodule
